fp_add_arbiter: RTL and testbench

- Shares one external pipelined IEEE-754 single-precision adder among N_REQ requesters in the Maxnet datapath, e.g. the per-neuron lateral-inhibition accumulators.
- Grants requesters round-robin, at most one issue per cycle.
- Tracks in-flight operations by tag, so each result returns to the requester that issued it.
- Sits between the neuron update sequencers and the shared FP adder.

---
 rtl/fp_add_arbiter.sv | 136 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ===========================================================================
// fp_add_arbiter : round-robin share of one pipelined FP32 adder, results
// routed back by tag. Optional macro FP_ADD_ARB_RELU_EN clamps negative sums.
// Rev 1.0
// ===========================================================================
module fp_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]    req_sub,
    output logic                add_valid,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    input  logic [31:0]         add_sum,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                busy
);
    localparam int            IDW = $clog2(N_REQ);
    localparam logic [IDW:0]  NR  = (IDW+1)'(N_REQ);

    logic [N_REQ-1:0] pending;
    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] eligible;
    logic [IDW-1:0]   cand [N_REQ];
    logic [31:0]      op_a [N_REQ];
    logic [31:0]      op_b [N_REQ];
    logic             found;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   issue_id;
    logic             tag_v  [ADD_LAT];
    logic [IDW-1:0]   tag_id [ADD_LAT];
    logic [N_REQ-1:0] done;
    logic [31:0]      sum_act;

    assign eligible = req_valid & ~pending;

    // cand[i] is the index visited i-th when searching upward from ptr
    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        localparam logic [IDW:0] OFF = (IDW+1)'(i);
        logic [IDW:0] sum_raw;
        logic [IDW:0] sum_wrap;
        assign sum_raw  = {1'b0, ptr} + OFF;
        assign sum_wrap = (sum_raw >= NR) ? (sum_raw - NR) : sum_raw;
        assign cand[i]  = sum_wrap[IDW-1:0];
        assign op_a[i]  = req_a[32*i +: 32];
        assign op_b[i]  = req_b[32*i +: 32] ^ {req_sub[i], 31'b0};
    end

    always_comb begin
        found = 1'b0;
        gidx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && eligible[cand[k]]) begin
                found = 1'b1;
                gidx  = cand[k];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) begin
            req_ready[gidx] = 1'b1;
        end
    end

    assign done = tag_v[ADD_LAT-1] ? (N_REQ'(1) << tag_id[ADD_LAT-1]) : '0;

`ifdef FP_ADD_ARB_RELU_EN
    assign sum_act = add_sum[31] ? 32'h0000_0000 : add_sum;
`else
    assign sum_act = add_sum;
`endif

    // Grant bookkeeping and operand issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ptr       <= '0;
            add_valid <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            issue_id  <= '0;
        end else begin
            pending   <= (pending & ~done) | req_ready;
            add_valid <= found;
            if (found) begin
                ptr      <= (gidx == IDW'(N_REQ-1)) ? '0 : gidx + 1'b1;
                add_a    <= op_a[gidx];
                add_b    <= op_b[gidx];
                issue_id <= gidx;
            end
        end
    end

    // Tag pipeline fed from the issue stage so its tail lines up with add_sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= add_valid;
            tag_id[0] <= issue_id;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= done;
            if (tag_v[ADD_LAT-1]) begin
                rsp_data <= sum_act;
            end
        end
    end

    assign busy = |pending;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// tb_fp_add_arbiter : vector table, corner sequences and random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_fp_add_arbiter;
    localparam int N = 4;
    localparam int L = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a = '0;
    logic [32*N-1:0] req_b = '0;
    logic [N-1:0]    req_sub = '0;
    logic            add_valid;
    logic [31:0]     add_a, add_b, add_sum, rsp_data;
    logic [N-1:0]    rsp_valid;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(.N_REQ(N), .ADD_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    // Opaque adder: exact FP results for the directed operand pairs, a mix otherwise
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_BF800000: return 32'h40000000;
            64'h3F800000_C0000000: return 32'hBF800000;
            64'h80000000_80000000: return 32'h80000000;
            64'h40000000_40000000: return 32'h40800000;
            default:               return {a[31] ^ b[30], a[30:0] ^ {b[7:0], b[30:8]}};
        endcase
    endfunction

    function automatic logic [31:0] act(input logic [31:0] s);
`ifdef FP_ADD_ARB_RELU_EN
        return s[31] ? 32'h0 : s;
`else
        return s;
`endif
    endfunction

    logic [31:0] apipe [L];
    always @(posedge clk) begin
        apipe[0] <= add_valid ? fadd(add_a, add_b) : 32'hDEAD_BEEF;
        for (int k = 1; k < L; k++) apipe[k] <= apipe[k-1];
    end
    assign add_sum = apipe[L-1];

    typedef struct { int due; int id; logic [31:0] data; } rsp_t;
    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic sub;
                     logic [31:0] exp_b; logic [31:0] exp_sum; } vec_t;

    rsp_t        rq[$];
    logic [N-1:0] m_pend = '0;
    int          m_ptr = 0;
    int          cyc = 0;
    logic        m_iss = 1'b0;
    logic [31:0] m_iss_a, m_iss_b;
    logic [31:0] m_add_a = '0, m_add_b = '0, m_rd = '0;
    int          acc_id[$], acc_cy[$], rsp_id[$], rsp_cy[$];
    logic [N-1:0] last_acc = '0;
    int          mode = 0;
    logic [N-1:0] mask = '0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_valid[i]       = 1'b1;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_sub[i]         = s;
    endtask

    // Model of one cycle, evaluated mid-cycle
    task automatic monitor();
        logic [N-1:0] exp_rv, exp_rdy, elig;
        logic         exp_av;
        rsp_t         e;
        int           idx, g;
        cyc++;
        last_acc = req_valid & req_ready;
        if (!rst_n) begin
            rq.delete();
            m_pend = '0; m_ptr = 0; m_iss = 1'b0;
            m_add_a = '0; m_add_b = '0; m_rd = '0;
            return;
        end
        exp_rv = '0;
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            exp_rv[e.id] = 1'b1;
            m_rd = e.data;
            m_pend[e.id] = 1'b0;
            rsp_id.push_back(e.id);
            rsp_cy.push_back(cyc);
        end
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, m_rd);
        chk("busy", busy, |m_pend);
        exp_av = m_iss;
        if (m_iss) begin
            m_add_a = m_iss_a;
            m_add_b = m_iss_b;
        end
        m_iss = 1'b0;
        chk("add_valid", add_valid, exp_av);
        chk("add_a", add_a, m_add_a);
        chk("add_b", add_b, m_add_b);
        elig = req_valid & ~m_pend;
        exp_rdy = '0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && elig[idx]) g = idx;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        if (g >= 0) begin
            m_pend[g] = 1'b1;
            m_ptr = (g + 1) % N;
            m_iss = 1'b1;
            m_iss_a = req_a[32*g +: 32];
            m_iss_b = req_b[32*g +: 32] ^ {req_sub[g], 31'b0};
            e.due = cyc + L + 2;
            e.id = g;
            e.data = act(fadd(m_iss_a, m_iss_b));
            rq.push_back(e);
            acc_id.push_back(g);
            acc_cy.push_back(cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (mode != 0 && last_acc[i]) req_valid[i] = 1'b0;
            if (mode == 1 && mask[i] && rsp_valid[i])
                set_req(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
            if (mode == 2 && !req_valid[i] && $urandom_range(1, 0) == 1)
                set_req(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        mode = 0;
        req_valid = '0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            step();
            if (last_acc[i]) ok = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        set_req(v.id, v.a, v.b, v.sub);
        wait_accept(v.id, ok);
        req_valid[v.id] = 1'b0;
        if (!ok) begin
            chk("vec accept timeout", 32'd0, 32'd1);
            return;
        end
        chk("vec add_valid", add_valid, 1);
        chk("vec add_a", add_a, v.a);
        chk("vec add_b", add_b, v.exp_b);
        chk("vec busy issue", busy, 1);
        for (int k = 1; k <= L + 1; k++) begin
            step();
            if (k <= L) begin
                chk("vec busy inflight", busy, 1);
                chk("vec rsp early", rsp_valid, 0);
            end else begin
                chk("vec busy done", busy, 0);
                chk("vec rsp_valid", rsp_valid, 32'd1 << v.id);
                chk("vec rsp_data", rsp_data, act(v.exp_sum));
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        bit   ok;
        int   s, r, n;
        vt[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 32'h40400000};
        vt[1] = '{1, 32'h40400000, 32'h3F800000, 1'b1, 32'hBF800000, 32'h40000000};
        vt[2] = '{2, 32'h3F800000, 32'h40000000, 1'b1, 32'hC0000000, 32'hBF800000};
        vt[3] = '{3, 32'h3F800000, 32'hC0000000, 1'b0, 32'hC0000000, 32'hBF800000};
        vt[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 32'h80000000};
        vt[5] = '{3, 32'h40000000, 32'hC0000000, 1'b1, 32'h40000000, 32'h40800000};

        repeat (3) step();
        chk("reset add_valid", add_valid, 0);
        chk("reset add_a", add_a, 0);
        chk("reset add_b", add_b, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Reset two cycles after an accept drops the operation
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        wait_accept(1, ok);
        req_valid = '0;
        chk("midreset accept", 32'(ok), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("midreset add_valid", add_valid, 0);
        chk("midreset add_a", add_a, 0);
        chk("midreset add_b", add_b, 0);
        chk("midreset rsp_valid", rsp_valid, 0);
        chk("midreset rsp_data", rsp_data, 0);
        chk("midreset busy", busy, 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < L + 4; k++) begin
            step();
            chk("midreset no rsp", rsp_valid, 0);
        end
        run_vec(vt[0]);

        // Contention: all four requesters right after reset, held high
        apply_reset(2);
        s = acc_id.size();
        r = rsp_id.size();
        for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom, 1'b0);
        repeat (12) step();
        req_valid = '0;
        if (acc_id.size() >= s + 5 && rsp_id.size() >= r + 4) begin
            for (int j = 0; j < N; j++) begin
                chk("cont grant order", acc_id[s+j], j);
                chk("cont grant cycle", acc_cy[s+j] - acc_cy[s], j);
                chk("cont rsp order", rsp_id[r+j], j);
                chk("cont rsp cycle", rsp_cy[r+j], acc_cy[s+j] + L + 2);
            end
            chk("cont regrant id", acc_id[s+4], 0);
            chk("cont regrant cycle", acc_cy[s+4], rsp_cy[r]);
        end else begin
            chk("cont log size", 32'd0, 32'd1);
        end

        // Fairness: 0 and 2 re-request on every response
        apply_reset(2);
        s = acc_id.size();
        mode = 1;
        mask = 4'b0101;
        set_req(0, $urandom, $urandom, 1'b0);
        set_req(2, $urandom, $urandom, 1'b1);
        repeat (40) step();
        mode = 0;
        req_valid = '0;
        n = acc_id.size() - s;
        chk("fair accept count", 32'(n >= 8), 1);
        if (n > 0) chk("fair first", acc_id[s], 0);
        for (int j = s + 1; j < acc_id.size(); j++)
            chk("fair alternate", 32'(acc_id[j] != acc_id[j-1]), 1);

        // Random traffic
        apply_reset(2);
        s = acc_id.size();
        mode = 2;
        repeat (3000) step();
        mode = 0;
        req_valid = '0;
        repeat (L + 4) step();
        chk("random activity", 32'(acc_id.size() - s >= 500), 1);
        chk("random drained", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
